acc_drain: RTL and testbench
============================

ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 The block SHALL take parameter CORE_NUM, default 8, giving the number of cores in the acc chain (legal range 1..64).
REQ-002 The block SHALL take parameter DATA_W, default 32, giving the width of one accumulator word.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL provide port start, input, 1, a pulse meaning all cores have finished accumulating.
REQ-006 The block SHALL provide port busy, output, 1, high in every state except IDLE.
REQ-007 The block SHALL provide port update, output, 1, which loads every core's chain register from its accumulator.
REQ-008 The block SHALL provide port out_period, output, 1, the chain load/shift enable to all cores.
REQ-009 The block SHALL provide port acc_in, input, DATA_W, the chain output word from the last core.
REQ-010 The block SHALL provide port m_tdata, output, DATA_W, the stream data.
REQ-011 The block SHALL provide port m_tvalid, output, 1, the stream valid.
REQ-012 The block SHALL provide port m_tready, input, 1, the stream ready from the downstream consumer.
REQ-013 The block SHALL provide port m_tlast, output, 1, high with the CORE_NUM-th word.
REQ-014 The block SHALL provide port done, output, 1, a one-cycle pulse after the final word is accepted.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, DRAIN and LAST.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD; start SHALL be ignored in every other state.
REQ-017 LOAD SHALL last one cycle with update=1 and out_period=1, then move to DRAIN; update SHALL be 0 in every other state.
REQ-018 In DRAIN, a capture SHALL occur in any cycle where (!m_tvalid || m_tready): m_tdata<=acc_in, m_tvalid<=1 and the capture counter increments.
REQ-019 A capture that is not the CORE_NUM-th SHALL assert out_period=1 in the same cycle, so that acc_in holds the next word one cycle later.
REQ-020 The CORE_NUM-th capture SHALL NOT assert out_period, SHALL set m_tlast<=1, and SHALL move the FSM to LAST.
REQ-021 out_period SHALL be 0 in every cycle that is not in LOAD and has no qualifying capture.
REQ-022 With m_tready held at 1, DRAIN SHALL capture one word per cycle with no bubbles.
REQ-023 Once m_tvalid=1, m_tvalid, m_tdata and m_tlast SHALL remain stable until the cycle in which m_tready=1.
REQ-024 A handshake in DRAIN with no new capture SHALL clear m_tvalid.
REQ-025 In LAST, a handshake SHALL clear m_tvalid and m_tlast, pulse done=1 for exactly one cycle, and move the FSM to IDLE.
REQ-026 With CORE_NUM=1, LOAD SHALL be followed by exactly one capture carrying m_tlast=1 and SHALL produce zero shift pulses.
REQ-027 Words SHALL be emitted in chain order, the last core's word first, passed through unmodified.
REQ-028 The capture counter SHALL be $clog2(CORE_NUM+1) bits wide and SHALL clear on entering LOAD.

Reset
REQ-029 When rst=1, the FSM SHALL go to IDLE immediately, regardless of the current state.
REQ-030 Reset SHALL drive m_tvalid, m_tlast, update, out_period, done and busy to 0, and m_tdata and the counter to 0.
REQ-031 A reset asserted mid-drain SHALL abandon the packet, so no further words and no done pulse appear.
REQ-032 The first start after reset deassertion SHALL begin a complete new packet.

Structure
REQ-033 DATA_W, the CORE_NUM default, and the state enum typedef (IDLE, LOAD, DRAIN, LAST) SHALL reside in shared package hpu_pkg.
REQ-034 The output holding register, with its capture/hold logic, SHALL be one sub-module named acc_out_slice; the FSM and counter SHALL stay in acc_drain.

Verification
REQ-035 Scenario: CORE_NUM=8, m_tready=1, chain model holding 0x1000..0x1007, start pulse -> update for 1 cycle; 8 consecutive beats 0x1000..0x1007; m_tlast on beat 8; 7 out_period shift pulses; done 1 cycle after beat 8.
REQ-036 Scenario: m_tready toggling 1,0,0,1,... -> m_tdata and m_tvalid held stable through the stalls, no word lost or duplicated, out_period pulses only on captures.
REQ-037 Scenario: start pulsed again during DRAIN -> ignored; exactly 8 beats and a single done.
REQ-038 Scenario: rst asserted after beat 3 -> m_tvalid=0 immediately, no done pulse; a new start yields a full 8-beat packet starting at 0x1000.
REQ-039 Scenario: CORE_NUM=1, chain holding 0xDEADBEEF -> a single beat with m_tlast=1, zero shift pulses, done pulse.
REQ-040 Scenario: m_tready=0 for 20 cycles at the LAST state -> beat 8 held, busy=1, done only after the handshake.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared definitions for the accumulator drain path.
//   DATA_W        : width of one accumulator word
//   CORE_NUM_DEF  : default number of cores in the accumulator chain
//   drain_state_t : drain controller states
package hpu_pkg;

  localparam int DATA_W       = 32;
  localparam int CORE_NUM_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    LAST  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/acc_out_slice.sv
// Output holding register for the drain stream.
// Captures a word (with its last flag) when capture=1. Otherwise it drops
// valid/last when clear=1. Otherwise it holds its contents, which keeps
// data, valid and last stable while the consumer stalls.
//   clk, rst            : clock, asynchronous active-high reset
//   capture             : load data_in/last_in and raise m_tvalid
//   clear               : drop m_tvalid/m_tlast (accepted, nothing new)
//   data_in, last_in    : word and last flag to capture
//   m_tdata/m_tvalid/m_tlast : registered stream outputs
module acc_out_slice #(
  parameter int DATA_W = hpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (capture) begin
      m_tdata  <= data_in;
      m_tvalid <= 1'b1;
      m_tlast  <= last_in;
    end else if (clear) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Drains the accumulator chain into a valid/ready stream.
// On start, every core's chain register is loaded from its accumulator
// (update + out_period for one cycle). The chain is then shifted one word
// per capture until CORE_NUM words have been streamed out. The last core's
// word comes first.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : all cores finished accumulating
//   busy           : controller not idle
//   update         : load chain registers from accumulators
//   out_period     : chain load/shift enable
//   acc_in         : chain output word from the last core
//   m_tdata/m_tvalid/m_tready/m_tlast : output stream
//   done           : one-cycle pulse after the final word is accepted
module acc_drain #(
  parameter int CORE_NUM = hpu_pkg::CORE_NUM_DEF,
  parameter int DATA_W   = hpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              update,
  output logic              out_period,
  input  logic [DATA_W-1:0] acc_in,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              done
);

  import hpu_pkg::*;

  localparam int CNT_W = $clog2(CORE_NUM + 1);

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             final_cap;
  logic             handshake;
  logic             clear;

  // A capture fires whenever the holding register is empty or being emptied.
  assign capture   = (state == DRAIN) && (!m_tvalid || m_tready);
  assign final_cap = capture && (cnt == CNT_W'(CORE_NUM - 1));
  assign handshake = m_tvalid && m_tready;
  // An accepted word with nothing new behind it empties the register.
  assign clear     = handshake && !capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD;
      LOAD:                   state_nxt = DRAIN;
      DRAIN:   if (final_cap) state_nxt = LAST;
      LAST:    if (handshake) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    update     = (state == LOAD);
    // The final capture must not shift: the chain is already empty.
    out_period = (state == LOAD) || (capture && !final_cap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      else if (capture)           cnt <= cnt + 1'b1;
      done <= (state == LAST) && handshake;
    end
  end

  acc_out_slice #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .clear    (clear),
    .data_in  (acc_in),
    .last_in  (final_cap),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast)
  );

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: an 8-core instance and a 1-core instance share the clock and reset.
module tb_acc_drain;

  logic        clk;
  logic        rst;
  logic        start  [2];
  logic        tready [2];
  logic [31:0] acc_in [2];
  logic        busy   [2];
  logic        update [2];
  logic        outp   [2];
  logic        tvalid [2];
  logic        tlast  [2];
  logic        done   [2];
  logic [31:0] tdata  [2];

  int tot = 0;
  int bad = 0;

  acc_drain #(.CORE_NUM(8), .DATA_W(32)) dut8 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .update(update[0]),
    .out_period(outp[0]), .acc_in(acc_in[0]), .m_tdata(tdata[0]),
    .m_tvalid(tvalid[0]), .m_tready(tready[0]), .m_tlast(tlast[0]), .done(done[0])
  );

  acc_drain #(.CORE_NUM(1), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .update(update[1]),
    .out_period(outp[1]), .acc_in(acc_in[1]), .m_tdata(tdata[1]),
    .m_tvalid(tvalid[1]), .m_tready(tready[1]), .m_tlast(tlast[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Chain model: the cores' chain registers hold base+0 .. base+N-1. The last core's word is visible first.
  int idx [2] = '{0, 0};
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (update[u])    idx[u] <= 0;
      else if (outp[u]) idx[u] <= idx[u] + 1;
    end
  end
  assign acc_in[0] = 32'h0000_1000 + 32'(idx[0]);
  assign acc_in[1] = 32'hDEAD_BEEF + 32'(idx[1]);

  // Packet-level model and per-cycle checker.
  int          nb       [2] = '{8, 1};
  logic [31:0] base     [2] = '{32'h0000_1000, 32'hDEAD_BEEF};
  int          exp_idx  [2] = '{0, 0};
  int          shifts   [2] = '{0, 0};
  int          upds     [2] = '{0, 0};
  int          hs_cnt   [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  bit          pend     [2] = '{0, 0};
  bit          pv       [2] = '{0, 0};
  bit          pr       [2] = '{0, 0};
  bit          pl       [2] = '{0, 0};
  logic [31:0] pd       [2];
  logic [31:0] cap      [2][8];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        chk("rst_valid", tvalid[u], 0);
        chk("rst_last", tlast[u], 0);
        chk("rst_data", tdata[u], 0);
        chk("rst_update", update[u], 0);
        chk("rst_outp", outp[u], 0);
        chk("rst_done", done[u], 0);
        chk("rst_busy", busy[u], 0);
        exp_idx[u] = 0; shifts[u] = 0; upds[u] = 0; hs_cnt[u] = 0;
        pend[u] = 0; pv[u] = 0;
        continue;
      end
      chk("done_timing", done[u], pend[u]);
      pend[u] = 0;
      if (done[u]) begin
        chk("done_valid_clear", tvalid[u], 0);
        chk("shift_count", shifts[u], nb[u] - 1);
        chk("update_count", upds[u], 1);
        chk("beat_count", hs_cnt[u], nb[u]);
        done_cnt[u]++;
        shifts[u] = 0; upds[u] = 0; hs_cnt[u] = 0; exp_idx[u] = 0;
      end
      if (pv[u] && !pr[u]) begin
        chk("hold_valid", tvalid[u], 1);
        chk("hold_data", tdata[u], pd[u]);
        chk("hold_last", tlast[u], pl[u]);
      end
      if (update[u]) upds[u]++;
      if (outp[u] && !update[u]) begin
        shifts[u]++;
        chk("shift_on_capture", (!tvalid[u] || tready[u]) && busy[u], 1);
      end
      if (tvalid[u] && tready[u]) begin
        chk("beat_data", tdata[u], base[u] + 32'(exp_idx[u]));
        chk("beat_last", tlast[u], exp_idx[u] == nb[u] - 1);
        if (exp_idx[u] < 8) cap[u][exp_idx[u]] = tdata[u];
        if (exp_idx[u] == nb[u] - 1) pend[u] = 1;
        exp_idx[u]++;
        hs_cnt[u]++;
      end
      pv[u] = tvalid[u]; pr[u] = tready[u]; pd[u] = tdata[u]; pl[u] = tlast[u];
    end
  end

  // Stimulus: ready modes 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = stall 20 cycles on the last beat
  int rmode [2] = '{0, 0};
  int cyc   = 0;
  int stall = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      case (rmode[u])
        1: tready[u] = (cyc % 3 == 0);
        2: begin
          if (tvalid[u] && tlast[u] && stall < 20) begin
            tready[u] = 1'b0;
            stall++;
            chk("stall_busy", busy[u], 1);
            chk("stall_no_done", done[u], 0);
          end else begin
            tready[u] = 1'b1;
          end
        end
        default: tready[u] = 1'b1;
      endcase
    end
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget);
    int  d0;
    bit  ok;
    d0 = done_cnt[u];
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt[u] != d0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("done_seen", ok, 1);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start[0] = 0; start[1] = 0;
    tready[0] = 1; tready[1] = 1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Back-to-back drain, consumer always ready
    pulse_start(0);
    wait_done(0, 60);
    chk("s1_word0", cap[0][0], 32'h0000_1000);
    chk("s1_word3", cap[0][3], 32'h0000_1003);
    chk("s1_word7", cap[0][7], 32'h0000_1007);
    tick();
    chk("s1_idle", busy[0], 0);

    // Ready toggling 1,0,0
    rmode[0] = 1;
    pulse_start(0);
    wait_done(0, 200);
    chk("s2_word5", cap[0][5], 32'h0000_1005);
    rmode[0] = 0;
    tick();

    // Second start during DRAIN is ignored
    dc = done_cnt[0];
    pulse_start(0);
    repeat (3) tick();
    pulse_start(0);
    wait_done(0, 60);
    repeat (6) tick();
    chk("s3_single_done", done_cnt[0], dc + 1);
    chk("s3_idle", busy[0], 0);

    // Reset after beat 3 abandons the packet
    pulse_start(0);
    for (int i = 0; i < 40 && hs_cnt[0] < 3; i++) tick();
    chk("s4_three_beats", hs_cnt[0], 3);
    dc = done_cnt[0];
    rst = 1'b1;
    #1;
    chk("s4_valid_now", tvalid[0], 0);
    chk("s4_busy_now", busy[0], 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("s4_no_done", done_cnt[0], dc);
    pulse_start(0);
    wait_done(0, 60);
    chk("s4_word0", cap[0][0], 32'h0000_1000);
    chk("s4_word7", cap[0][7], 32'h0000_1007);

    // Single-core chain
    pulse_start(1);
    wait_done(1, 20);
    chk("s5_word", cap[1][0], 32'hDEAD_BEEF);
    chk("s5_done_cnt", done_cnt[1], 1);

    // Consumer stalls 20 cycles on the last beat
    rmode[0] = 2;
    stall = 0;
    pulse_start(0);
    wait_done(0, 100);
    chk("s6_stall_len", stall, 20);
    chk("s6_word7", cap[0][7], 32'h0000_1007);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
